thirty_two_bit_descrambler: RTL

Receive-side descrambler for the 32-bit XOR datapath. It removes an LFSR keystream from incoming 32-bit words by XORing each accepted word with the current key, then advances the key one step. It sits after the link and before the consumer. Input and output use valid/ready handshakes with a single registered output stage.

---
 rtl/thirty_two_bit_descrambler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/thirty_two_bit_descrambler.sv
// rtl/thirty_two_bit_descrambler.sv - receive-side LFSR descrambler for the 32-bit XOR datapath
//
// Each accepted word is XORed with the current key, and then the key advances
// one Galois LFSR step. The output has a single registered stage.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   seed_load  - one-cycle pulse: load key from seed (zero -> DEFAULT_SEED), enter RUN
//   seed       - new key value, sampled with seed_load
//   din        - scrambled input word
//   in_valid   - din is valid
//   in_ready   - block accepts din this cycle
//   dout       - descrambled word (registered)
//   out_valid  - dout is valid
//   out_ready  - consumer accepts dout this cycle
//   word_cnt   - words accepted since last seed_load or reset (wraps at 2^16)
//   running    - 1 once seeded (RUN state)

module thirty_two_bit_descrambler_key_step #(
  parameter logic [31:0] POLY = 32'h80200003
) (
  input  logic [31:0] key,
  output logic [31:0] key_next
);

  // Galois form: shift right, fold the feedback mask in when the bit shifted
  // out was a one.
  assign key_next = (key >> 1) ^ (key[0] ? POLY : 32'h0000_0000);

endmodule

module thirty_two_bit_descrambler #(
  parameter logic [31:0] POLY         = 32'h80200003,
  parameter logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [31:0] seed,
  input  logic [31:0] din,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] word_cnt,
  output logic        running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] key;
  logic [31:0] key_next;
  logic [31:0] seed_key;
  logic        accept;
  logic        drain;

  thirty_two_bit_descrambler_key_step #(
    .POLY (POLY)
  ) u_key_step (
    .key      (key),
    .key_next (key_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a seed load always lands in RUN; only reset leaves it.
  always_comb begin
    state_next = state;
    if (seed_load) begin
      state_next = RUN;
    end
  end

  // State-derived outputs.
  always_comb begin
    running = 1'b0;
    if (state == RUN) begin
      running = 1'b1;
    end
  end

  // Ready only depends on our own state and the consumer, never on in_valid,
  // so the producer may wait for ready before raising valid. A seed load
  // blocks input for that cycle so the old key is never used on it.
  assign in_ready = running & ~seed_load & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  // A zero seed would lock the LFSR at zero, so it is replaced.
  assign seed_key = (seed == 32'h0000_0000) ? DEFAULT_SEED : seed;

  // Key and word counter move only on seed loads and accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key      <= DEFAULT_SEED;
      word_cnt <= 16'h0000;
    end else if (seed_load) begin
      key      <= seed_key;
      word_cnt <= 16'h0000;
    end else if (accept) begin
      key      <= key_next;
      word_cnt <= word_cnt + 16'h0001;
    end
  end

  // Output stage. A pending word is untouched by seed_load and holds while
  // the consumer stalls; accept and drain together refill it in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else if (accept) begin
      dout      <= din ^ key;
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
